// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg: opcode constants, flag layout and flag derivation shared by the result stage
package alu_result_stage_pkg;
   localparam logic [3:0] ALU_OP_ADD = 4'b0000;
   localparam logic [3:0] ALU_OP_SUB = 4'b0001;
   localparam logic [3:0] ALU_OP_MAX = 4'b1000;
   localparam int CARRY_BIT = 4;
   localparam int NEG_BIT = 3;
   typedef struct packed {
      logic zero;
      logic carry;
      logic neg;
      logic err;
   } flags_t;
   localparam int FLAGS_W = $bits(flags_t);
   function automatic flags_t make_flags(input logic is_zero, input logic [CARRY_BIT:0] y_lo, input logic [3:0] ctrl);
      flags_t f;
      f.zero = is_zero;
      f.carry = (ctrl == ALU_OP_ADD || ctrl == ALU_OP_SUB) && y_lo[CARRY_BIT];
      f.neg = y_lo[NEG_BIT];
      f.err = ctrl > ALU_OP_MAX;
      return f;
   endfunction
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: valid/ready result bus between the ALU, the result stage and its consumer
interface alu_result_stage_if #(
   parameter int DATA_W = 8,
   parameter int CTRL_W = 4,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic in_valid, in_ready, out_valid, out_ready;
   logic out_zero, out_carry, out_neg, out_err;
   logic [DATA_W-1:0] in_y, out_y;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [CW-1:0] count;
   modport master(
      output in_valid, in_y, in_ctrl, out_ready,
      input in_ready, out_valid, out_y, out_ctrl, out_zero, out_carry, out_neg, out_err, count
   );
   modport slave(
      input in_valid, in_y, in_ctrl, out_ready,
      output in_ready, out_valid, out_y, out_ctrl, out_zero, out_carry, out_neg, out_err, count
   );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: power-of-two FIFO holding packed result entries; push/pop are pre-qualified by the caller
module alu_result_fifo #(
   parameter int W = 16,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   // pointers wrap naturally at DEPTH; simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + CW'(push) - CW'(pop);
      end
   // storage is not reset; the top masks it while the FIFO is empty
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;
   assign rdata = mem[rd_ptr];
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results with derived flags behind a valid/ready handshake (option: ALU_RESULT_BYPASS_EN)
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CTRL_W = 4,
   parameter int DEPTH = 2
) (
   input logic clk,
   input logic rst_n,
   alu_result_stage_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = CTRL_W + DATA_W + FLAGS_W;
   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] y;
      flags_t flags;
   } entry_t;
   entry_t in_e, head, out_e;
   logic [CW-1:0] count;
   logic have, bypass, push, pop;
   assign in_e = {bus.in_ctrl, bus.in_y, make_flags(bus.in_y == '0, bus.in_y[CARRY_BIT:0], 4'(bus.in_ctrl))};
   assign have = count != '0;
`ifdef ALU_RESULT_BYPASS_EN
   assign bypass = !have && bus.in_valid && bus.out_ready;
`else
   assign bypass = 1'b0;
`endif
   assign bus.in_ready = count != CW'(DEPTH);
   assign push = bus.in_valid && bus.in_ready && !bypass;
   assign pop = have && bus.out_ready;
   alu_result_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(push),
      .pop(pop),
      .wdata(in_e),
      .rdata(head),
      .count(count)
   );
   // present the head entry, or the live input when bypassing; everything reads 0 when idle
   always_comb out_e = have ? head : bypass ? in_e : '0;
   assign bus.out_valid = have || bypass;
   assign bus.out_y = out_e.y;
   assign bus.out_ctrl = out_e.ctrl;
   assign bus.out_zero = out_e.flags.zero;
   assign bus.out_carry = out_e.flags.carry;
   assign bus.out_neg = out_e.flags.neg;
   assign bus.out_err = out_e.flags.err;
   assign bus.count = count;
endmodule
